// File: rtl/display_scan_mux_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scanner.
// Segment vectors are ordered {a,b,c,d,e,f,g}, active high.
package display_scan_mux_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  function automatic logic an_level(
    input logic lit,
    input logic active_low
  );
    return lit ^ active_low;
  endfunction

endpackage

// File: rtl/display_scan_mux_onedigit.sv
// Combinational hex nibble to 7-segment decoder.
// Output bit order {a,b,c,d,e,f,g}, active high.
module display_onedigit
  import display_scan_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Hex glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode display scanner with a
// double-buffered load port committed at frame end.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE      = 50000,
  parameter int GUARD         = 16,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int DW = 4 * NUM_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  lz_blank,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DW-1:0]         load_data,
  input  logic [NUM_DIGITS-1:0] load_dp,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [DW-1:0]         pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  slot_end;
  logic                  last_slot;
  logic                  tick;
  logic                  accept;
  logic                  commit;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_vec;

  assign slot_end  = (cnt_q == CW'(PRESCALE - 1));
  assign last_slot = (idx_q == IW'(NUM_DIGITS - 1));
  assign tick      = enable && slot_end && last_slot;
  assign accept    = load_valid && !pend_full_q;
  assign commit    = pend_full_q && (tick || !enable);

  assign load_ready = !pend_full_q;
  assign frame_tick = tick;
  assign digit_idx  = idx_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;

  assign nibble = act_data_q[4*int'(idx_q) +: 4];

  display_onedigit u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Prescaler and slot index, held at zero while disabled
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (slot_end) begin
      cnt_d = '0;
      idx_d = last_slot ? '0 : idx_q + IW'(1);
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Pending buffer fills on handshake, drains into active at frame end
  always_comb begin
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    if (accept) begin
      pend_data_d = load_data;
      pend_dp_d   = load_dp;
      pend_full_d = 1'b1;
    end
    if (commit) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
  end

  // Leading-zero mask: digit i blanked if it and all above are zero
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_vec   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero  = all_zero && (act_data_q[4*i +: 4] == 4'h0);
      lz_vec[i] = all_zero;
    end
  end

  // Next display outputs for the current slot and guard window
  always_comb begin
    logic lit;
    lit   = enable && (cnt_q >= CW'(GUARD));
    seg_d = (enable && !(lz_blank && lz_vec[idx_q])) ?
            dec_seg : SEG_BLANK;
    dp_d  = enable && act_dp_q[idx_q];
    an_d  = AN_OFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = an_level(lit && (idx_q == IW'(i)),
                         AN_ACTIVE_LOW);
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
      an_q        <= AN_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux (4 digits, PRESCALE 8, GUARD 2).
// Each lit slot is matched against the queue of expected slots.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        lz_blank = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic        load_ready;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_lit = 1'b0;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] SA = 7'b1110111;
  localparam logic [6:0] SF = 7'b1000111;

  always #5 clk = ~clk;

  display_scan_mux #(
    .NUM_DIGITS    (4),
    .PRESCALE      (8),
    .GUARD         (2),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // Monitor: first lit cycle of every slot is compared with the queue head
  always @(negedge clk) begin
    logic lit;
    exp_t e;
    lit = (an != 4'hF);
    if (lit && !prev_lit && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_chk++;
      if ({an, seg, dp} !== e) begin
        n_fail++;
        $display("FAIL slot: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 an, seg, dp, e.an, e.seg, e.dp);
      end
    end
    prev_lit = lit;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dps);
    sb_q.push_back({4'b1110, s0, dps[0]});
    sb_q.push_back({4'b1101, s1, dps[1]});
    sb_q.push_back({4'b1011, s2, dps[2]});
    sb_q.push_back({4'b0111, s3, dps[3]});
  endtask

  task automatic wait_tick(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (frame_tick !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: frame_tick timeout, got 0 want 1", name);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s: %0d slots not seen, want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p,
                           input string name);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_dp    = p;
    @(negedge clk);
    load_valid = 1'b0;
    check(name, load_ready, 1'b0);
  endtask

  initial begin
    int k;
    #1 rst_n = 1'b0;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h00);
    check("rst_dp", dp, 1'b0);
    check("rst_ready", load_ready, 1'b1);
    check("rst_tick", frame_tick, 1'b0);

    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Word 12AF with decimal point on digit 0
    load_word(16'h12AF, 4'b0001, "ready_after_load");
    wait_tick("tick_12af");
    push_frame(SF, SA, S2, S1, 4'b0001);
    @(negedge clk);
    check("ready_after_commit", load_ready, 1'b1);
    @(negedge clk);
    check("guard_c0", an, 4'hF);
    @(negedge clk);
    check("guard_c1", an, 4'hF);
    @(negedge clk);
    check("slot0_lit", an, 4'b1110);
    wait_drain("drain_12af");

    // Leading-zero blanking of 0050
    lz_blank = 1'b1;
    load_word(16'h0050, 4'b0000, "ready_after_0050");
    wait_tick("tick_0050");
    push_frame(S0, S5, 7'h00, 7'h00, 4'b0000);
    wait_drain("drain_0050");
    lz_blank = 1'b0;

    // Back-pressure: 2222 held while 1111 is pending
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'h1111;
    load_dp    = 4'b0000;
    @(negedge clk);
    load_data  = 16'h2222;
    check("hold_ready0", load_ready, 1'b0);
    wait_tick("tick_1111");
    check("ready_at_tick", load_ready, 1'b0);
    push_frame(S1, S1, S1, S1, 4'b0000);
    @(negedge clk);
    check("ready_after_tick", load_ready, 1'b1);
    @(negedge clk);
    load_valid = 1'b0;
    check("accepted_2222", load_ready, 1'b0);
    wait_tick("tick_2222");
    push_frame(S2, S2, S2, S2, 4'b0000);
    wait_drain("drain_2222");

    // Disable mid-slot on digit 2
    k = 0;
    while (digit_idx !== 2'd2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reach_digit2", digit_idx, 2'd2);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_an", an, 4'hF);
    check("dis_seg", seg, 7'h00);
    check("dis_dp", dp, 1'b0);
    check("dis_idx", digit_idx, 2'd0);
    check("dis_tick", frame_tick, 1'b0);
    repeat (3) @(negedge clk);
    check("dis_idx_held", digit_idx, 2'd0);
    enable = 1'b1;
    push_frame(S2, S2, S2, S2, 4'b0000);
    k = 0;
    while (frame_tick !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("restart_tick_cycles", k, 31);
    wait_drain("drain_restart");

    // Async reset while a word is pending
    load_word(16'h9876, 4'b1111, "ready_after_9876");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h00);
    check("mid_rst_dp", dp, 1'b0);
    check("mid_rst_ready", load_ready, 1'b1);
    check("mid_rst_idx", digit_idx, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(S0, S0, S0, S0, 4'b0000);
    push_frame(S0, S0, S0, S0, 4'b0000);
    wait_drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
